// File: rtl/clk16dly_code_ramp.sv
// Thermometer select controller for the 16-step clock delay cell: ramps one tap per settle window.
// Define CLK16DLY_FAST_LOAD_EN to add fast_load, which jumps straight to the target in a single step.
module clk16dly_code_ramp #(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned RST_CODE   = 0
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        tgt_valid,
  input  logic [3:0]  tgt_code,
`ifdef CLK16DLY_FAST_LOAD_EN
  input  logic        fast_load,
`endif
  output logic        tgt_ready,
  output logic [14:0] rsel,
  output logic [3:0]  cur_code,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] RST_C       = 4'(RST_CODE);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, STEP, SETTLE} state_t;

  state_t     state;
  logic [3:0] tgt;
  logic [7:0] cnt;
  logic       fast;
  logic [3:0] step_code;

  function automatic logic [14:0] thermo(input logic [3:0] code);
    logic [14:0] t;
    for (int i = 0; i < 15; i++) t[i] = (code > 4'(i));
    return t;
  endfunction

  // The target bounds the ramp, so +/-1 can never wrap past 0 or 15.
  always_comb begin
    step_code = cur_code;
    if (fast)                 step_code = tgt;
    else if (tgt > cur_code)  step_code = cur_code + 4'd1;
    else if (tgt < cur_code)  step_code = cur_code - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state    <= IDLE;
      cur_code <= RST_C;
      rsel     <= thermo(RST_C);
      tgt      <= RST_C;
      cnt      <= 8'd0;
      fast     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (tgt_valid) begin
            tgt <= tgt_code;
`ifdef CLK16DLY_FAST_LOAD_EN
            fast <= fast_load;
`else
            fast <= 1'b0;
`endif
            if (tgt_code == cur_code) done  <= 1'b1;
            else                      state <= STEP;
          end
        end
        STEP: begin
          cur_code <= step_code;
          rsel     <= thermo(step_code);
          cnt      <= SETTLE_LOAD;
          state    <= SETTLE;
        end
        SETTLE: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (cur_code != tgt) begin
            state <= STEP;
          end else begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tgt_ready = (state == IDLE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_clk16dly_code_ramp.sv
// Directed bench for clk16dly_code_ramp: expected rsel steps and done cycles are queued at
// acceptance time and checked as the DUT produces them.
module tb_clk16dly_code_ramp;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        tgt_valid;
  logic [3:0]  tgt_code;
  logic        tgt_ready;
  logic [14:0] rsel;
  logic [3:0]  cur_code;
  logic        busy;
  logic        done;
`ifdef CLK16DLY_FAST_LOAD_EN
  logic        fast_load;
`endif

  clk16dly_code_ramp #(.SETTLE_CYC(S), .RST_CODE(0)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .tgt_valid (tgt_valid),
    .tgt_code  (tgt_code),
`ifdef CLK16DLY_FAST_LOAD_EN
    .fast_load (fast_load),
`endif
    .tgt_ready (tgt_ready),
    .rsel      (rsel),
    .cur_code  (cur_code),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [14:0] val;
  } exp_t;

  exp_t        rsel_q[$];
  int          done_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          model_code = 0;
  int          last_e0 = 0;
  bit          mon_en = 0;
  bit          onebit = 1;
  logic [14:0] prev_rsel;

  function automatic logic [14:0] therm_model(input int c);
    logic [15:0] w;
    w = (16'd1 << c) - 16'd1;
    return w[14:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and observe outputs on the falling edge.
  task automatic tick();
    exp_t e;
    int   dc;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (mon_en) begin
      if (rsel !== prev_rsel) begin
        checks++;
        assert (rsel_q.size() != 0) else begin
          errors++;
          $error("FAIL rsel_extra: observed %0h at cycle %0d expected no change", rsel, cyc);
        end
        if (rsel_q.size() != 0) begin
          e = rsel_q.pop_front();
          chk("rsel_val", rsel, e.val);
          chk("rsel_cyc", cyc, e.cyc);
          if (onebit) chk("rsel_onebit", $countones(rsel ^ prev_rsel), 1);
        end
      end
      prev_rsel = rsel;
      if (done === 1'b1) begin
        checks++;
        assert (done_q.size() != 0) else begin
          errors++;
          $error("FAIL done_extra: observed done at cycle %0d expected none", cyc);
        end
        if (done_q.size() != 0) begin
          dc = done_q.pop_front();
          chk("done_cyc", cyc, dc);
        end
      end
    end
  endtask

  task automatic start(input int code, input bit fast);
    exp_t e;
    int   c, n;
    chk("tgt_ready_idle", tgt_ready, 1);
    last_e0 = cyc + 1;
    c = model_code;
    n = (code > c) ? code - c : c - code;
    if (n == 0) begin
      done_q.push_back(last_e0);
    end else if (fast) begin
      e.cyc = last_e0 + 1; e.val = therm_model(code);
      rsel_q.push_back(e);
      done_q.push_back(last_e0 + 1 + S);
    end else begin
      for (int k = 1; k <= n; k++) begin
        c = (c < code) ? c + 1 : c - 1;
        e.cyc = last_e0 + (k - 1) * (S + 1) + 1;
        e.val = therm_model(c);
        rsel_q.push_back(e);
      end
      done_q.push_back(last_e0 + n * (S + 1));
    end
    model_code = code;
    tgt_valid = 1'b1;
    tgt_code  = 4'(code);
`ifdef CLK16DLY_FAST_LOAD_EN
    fast_load = fast;
`endif
    tick();
    tgt_valid = 1'b0;
`ifdef CLK16DLY_FAST_LOAD_EN
    fast_load = 1'b0;
`endif
  endtask

  task automatic finish_ramp(input int budget);
    int k;
    k = 0;
    while ((rsel_q.size() != 0 || done_q.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    chk("ramp_complete", rsel_q.size() + done_q.size(), 0);
    chk("cur_code_final", cur_code, model_code);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    rst_b = 1'b0; tgt_valid = 1'b0; tgt_code = 4'd0;
`ifdef CLK16DLY_FAST_LOAD_EN
    fast_load = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_rsel", rsel, 0);
    chk("rst_cur_code", cur_code, 0);
    chk("rst_tgt_ready", tgt_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_b = 1'b1;
    tick();
    prev_rsel = rsel;
    mon_en = 1;

    // 0 -> 3: steps at E1, E6, E11, done at E15
    start(3, 0);
    chk("busy_in_ramp", busy, 1);
    chk("ready_in_ramp", tgt_ready, 0);
    finish_ramp(100);

    start(15, 0);
    finish_ramp(200);

    // 15 -> 0 with a competing target held that must be ignored
    start(0, 0);
    tgt_valid = 1'b1; tgt_code = 4'd5;
    repeat (20) tick();
    chk("busy_hold_valid", busy, 1);
    chk("ready_hold_valid", tgt_ready, 0);
    tgt_valid = 1'b0;
    finish_ramp(200);
    chk("rsel_at_zero", rsel, 0);

    start(7, 0);
    finish_ramp(100);
    // Same-code target: done at E0, no busy
    start(7, 0);
    chk("same_busy_e0", busy, 0);
    chk("same_done_e0", done, 1);
    tick();
    chk("same_busy_e1", busy, 0);
    chk("same_done_e1", done, 0);
    chk("same_queue_empty", done_q.size(), 0);

    start(0, 0);
    finish_ramp(100);

    // Reset during SETTLE of a 0 -> 9 ramp
    start(9, 0);
    while (cyc < last_e0 + 7) tick();
    rsel_q.delete();
    done_q.delete();
    begin
      exp_t e;
      e.cyc = cyc + 1; e.val = therm_model(0);
      rsel_q.push_back(e);
    end
    onebit = 0;
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    onebit = 1;
    model_code = 0;
    chk("midrst_cur_code", cur_code, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", tgt_ready, 1);
    chk("midrst_done", done, 0);
    repeat (20) tick();
    chk("midrst_no_done", done_q.size() + rsel_q.size(), 0);

    start(2, 0);
    finish_ramp(100);

`ifdef CLK16DLY_FAST_LOAD_EN
    start(0, 0);
    finish_ramp(100);
    onebit = 0;
    start(12, 1);
    finish_ramp(100);
    chk("fast_rsel", rsel, 15'h0FFF);
    onebit = 1;
`endif

    repeat (5) tick();
    chk("queues_drained", rsel_q.size() + done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
